// File: rtl/fu_issue_arbiter.sv
// fu_issue_arbiter
//   Per-cycle issue select for the out-of-order issue queue. For every
//   functional unit (FU) one ready entry carrying that FU's tag is chosen by
//   a per-FU round-robin scan. A chosen entry is registered as a grant, and
//   the FU is then held busy for FU_BUSY_CYCLES cycles, counting the grant
//   cycle. Stalled or busy FUs are skipped. A flush drops the pending
//   selection and clears the busy state.
//
// Ports
//   clk           in   clock, all state on the rising edge
//   reset_n       in   synchronous active-low reset
//   req_valid     in   [NUM_ENTRIES]     entry i ready to issue
//   req_fu        in   [2*NUM_ENTRIES]   FU tag of entry i at [2i+1:2i]
//   fu_stall      in   [NUM_FU]          FU f cannot accept this cycle
//   flush         in   pipeline flush
//   grant_valid   out  [NUM_FU]          registered: FU f issues this cycle
//   grant_idx     out  [IDX_BITS*NUM_FU] registered: granted entry for FU f
//   grant_onehot  out  [NUM_ENTRIES]     registered: OR of granted entries
//   fu_busy       out  [NUM_FU]          FU f inside its busy window
//
// Build option
//   ISSUE_ARB_PERF_EN : adds perf_grant_cnt (32 bits per FU, grants) and
//   perf_block_cnt (cycles in which a tagged request was held off by a busy
//   or stalled FU). Both counters wrap and are cleared only by reset.

module fu_issue_arbiter #(
    parameter int NUM_ENTRIES    = 64,
    parameter int IDX_BITS       = 6,
    parameter int NUM_FU         = 3,
    parameter int FU_BUSY_CYCLES = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_ENTRIES-1:0]       req_valid,
    input  logic [2*NUM_ENTRIES-1:0]     req_fu,
    input  logic [NUM_FU-1:0]            fu_stall,
    input  logic                         flush,
    output logic [NUM_FU-1:0]            grant_valid,
    output logic [IDX_BITS*NUM_FU-1:0]   grant_idx,
    output logic [NUM_ENTRIES-1:0]       grant_onehot,
    output logic [NUM_FU-1:0]            fu_busy
`ifdef ISSUE_ARB_PERF_EN
    ,
    output logic [32*NUM_FU-1:0]         perf_grant_cnt,
    output logic [31:0]                  perf_block_cnt
`endif
);

    localparam int CNT_BITS = $clog2(FU_BUSY_CYCLES + 1);

    logic [CNT_BITS-1:0]    busy_cnt [NUM_FU];
    logic [IDX_BITS-1:0]    rr_ptr   [NUM_FU];
    logic [1:0]             tag      [NUM_ENTRIES];

    logic [NUM_FU-1:0]      sel_valid;
    logic [IDX_BITS-1:0]    sel_idx  [NUM_FU];
    logic [NUM_ENTRIES-1:0] sel_onehot;
    logic [IDX_BITS-1:0]    scan_idx;

    always_comb begin
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            tag[i] = req_fu[2*i +: 2];
        end
    end

    always_comb begin
        for (int unsigned f = 0; f < NUM_FU; f++) begin
            fu_busy[f] = (busy_cnt[f] != '0);
        end
    end

    // Round-robin scan per FU: offset j from rr_ptr, wrapping through the
    // natural IDX_BITS overflow (NUM_ENTRIES is a power of two). The first
    // eligible entry wins. grant_onehot masks entries that the issue queue is
    // retiring this cycle, so they cannot be granted again.
    always_comb begin
        sel_valid  = '0;
        sel_onehot = '0;
        scan_idx   = '0;
        for (int unsigned f = 0; f < NUM_FU; f++) begin
            sel_idx[f] = '0;
        end
        for (int unsigned f = 0; f < NUM_FU; f++) begin
            if (busy_cnt[f] == '0 && !fu_stall[f] && !flush) begin
                for (int unsigned j = 0; j < NUM_ENTRIES; j++) begin
                    scan_idx = rr_ptr[f] + IDX_BITS'(j);
                    if (!sel_valid[f] && req_valid[scan_idx] &&
                        !grant_onehot[scan_idx] && tag[scan_idx] == 2'(f)) begin
                        sel_valid[f] = 1'b1;
                        sel_idx[f]   = scan_idx;
                    end
                end
            end
            if (sel_valid[f]) begin
                sel_onehot[sel_idx[f]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grant_valid  <= '0;
            grant_idx    <= '0;
            grant_onehot <= '0;
            for (int unsigned f = 0; f < NUM_FU; f++) begin
                busy_cnt[f] <= '0;
                rr_ptr[f]   <= '0;
            end
        end else if (flush) begin
            // rr_ptr and grant_idx are kept across a flush.
            grant_valid  <= '0;
            grant_onehot <= '0;
            for (int unsigned f = 0; f < NUM_FU; f++) begin
                busy_cnt[f] <= '0;
            end
        end else begin
            grant_valid  <= sel_valid;
            grant_onehot <= sel_onehot;
            for (int unsigned f = 0; f < NUM_FU; f++) begin
                if (sel_valid[f]) begin
                    grant_idx[IDX_BITS*f +: IDX_BITS] <= sel_idx[f];
                    rr_ptr[f]   <= sel_idx[f] + 1'b1;
                    busy_cnt[f] <= CNT_BITS'(FU_BUSY_CYCLES - 1);
                end else if (busy_cnt[f] != '0) begin
                    busy_cnt[f] <= busy_cnt[f] - 1'b1;
                end
            end
        end
    end

`ifdef ISSUE_ARB_PERF_EN
    logic fu_blocked;

    always_comb begin
        fu_blocked = 1'b0;
        for (int unsigned f = 0; f < NUM_FU; f++) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                if (req_valid[i] && !grant_onehot[i] && tag[i] == 2'(f) &&
                    (busy_cnt[f] != '0 || fu_stall[f])) begin
                    fu_blocked = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_grant_cnt <= '0;
            perf_block_cnt <= '0;
        end else begin
            for (int unsigned f = 0; f < NUM_FU; f++) begin
                if (sel_valid[f]) begin
                    perf_grant_cnt[32*f +: 32] <= perf_grant_cnt[32*f +: 32] + 32'd1;
                end
            end
            if (fu_blocked) begin
                perf_block_cnt <= perf_block_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// tb_fu_issue_arbiter
//   Drives three arbiters (FU_BUSY_CYCLES = 1, 3, 4) from a shared stimulus.
//   Directed scenarios come first, then random traffic. Every cycle, each
//   instance is compared against a reference model. The model keeps, per FU,
//   the absolute cycle from which the FU may be selected again, together with
//   a plain modulo round-robin pointer.

module tb_fu_issue_arbiter;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [63:0]  req_valid;
    logic [127:0] req_fu;
    logic [2:0]   fu_stall;
    logic         flush;

    logic [2:0]  gv_b1, gv_b3, gv_b4;
    logic [17:0] gi_b1, gi_b3, gi_b4;
    logic [63:0] oh_b1, oh_b3, oh_b4;
    logic [2:0]  fb_b1, fb_b3, fb_b4;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int          bc [3] = '{1, 3, 4};
    int          m_rr    [3][3];
    int          m_ready [3][3];
    int          m_gi    [3][3];
    logic [2:0]  m_gv [3];
    logic [63:0] m_oh [3];

    always #5 clk = ~clk;

    fu_issue_arbiter #(.NUM_ENTRIES(64), .IDX_BITS(6), .NUM_FU(3), .FU_BUSY_CYCLES(1)) u_b1 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_fu(req_fu),
        .fu_stall(fu_stall), .flush(flush), .grant_valid(gv_b1), .grant_idx(gi_b1),
        .grant_onehot(oh_b1), .fu_busy(fb_b1));

    fu_issue_arbiter #(.NUM_ENTRIES(64), .IDX_BITS(6), .NUM_FU(3), .FU_BUSY_CYCLES(3)) u_b3 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_fu(req_fu),
        .fu_stall(fu_stall), .flush(flush), .grant_valid(gv_b3), .grant_idx(gi_b3),
        .grant_onehot(oh_b3), .fu_busy(fb_b3));

    fu_issue_arbiter #(.NUM_ENTRIES(64), .IDX_BITS(6), .NUM_FU(3), .FU_BUSY_CYCLES(4)) u_b4 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_fu(req_fu),
        .fu_stall(fu_stall), .flush(flush), .grant_valid(gv_b4), .grant_idx(gi_b4),
        .grant_onehot(oh_b4), .fu_busy(fb_b4));

    function automatic logic [2:0] d_gv(input int n);
        case (n)
            0:       return gv_b1;
            1:       return gv_b3;
            default: return gv_b4;
        endcase
    endfunction

    function automatic logic [63:0] d_oh(input int n);
        case (n)
            0:       return oh_b1;
            1:       return oh_b3;
            default: return oh_b4;
        endcase
    endfunction

    function automatic logic [2:0] d_fb(input int n);
        case (n)
            0:       return fb_b1;
            1:       return fb_b3;
            default: return fb_b4;
        endcase
    endfunction

    function automatic logic [5:0] d_gidx(input int n, input int f);
        logic [17:0] v;
        case (n)
            0:       v = gi_b1;
            1:       v = gi_b3;
            default: v = gi_b4;
        endcase
        return v[6*f +: 6];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // The model applies the rules to the inputs present during cycle 'cyc'.
    // It produces the outputs expected in cycle cyc+1.
    task automatic model_update();
        int         k;
        bit         found;
        logic [2:0]  ngv;
        logic [63:0] noh;
        for (int n = 0; n < 3; n++) begin
            if (!reset_n) begin
                m_gv[n] = '0;
                m_oh[n] = '0;
                for (int f = 0; f < 3; f++) begin
                    m_gi[n][f] = 0; m_rr[n][f] = 0; m_ready[n][f] = 0;
                end
            end else if (flush) begin
                m_gv[n] = '0;
                m_oh[n] = '0;
                for (int f = 0; f < 3; f++) m_ready[n][f] = 0;
            end else begin
                ngv = '0;
                noh = '0;
                for (int f = 0; f < 3; f++) begin
                    found = 0;
                    if (!fu_stall[f] && cyc >= m_ready[n][f]) begin
                        for (int j = 0; j < 64; j++) begin
                            k = (m_rr[n][f] + j) % 64;
                            if (!found && req_valid[k] && !m_oh[n][k] && int'(req_fu[2*k +: 2]) == f) begin
                                found         = 1;
                                ngv[f]        = 1'b1;
                                m_gi[n][f]    = k;
                                m_rr[n][f]    = (k + 1) % 64;
                                m_ready[n][f] = cyc + bc[n];
                                noh[k]        = 1'b1;
                            end
                        end
                    end
                end
                m_gv[n] = ngv;
                m_oh[n] = noh;
            end
        end
    endtask

    task automatic compare_all();
        logic [2:0] eb;
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("model_gv[%0d]@%0d", n, cyc), 64'(d_gv(n)), 64'(m_gv[n]));
            for (int f = 0; f < 3; f++) begin
                chk($sformatf("model_gi[%0d][%0d]@%0d", n, f, cyc), 64'(d_gidx(n, f)), 64'(m_gi[n][f]));
                eb[f] = (cyc < m_ready[n][f]);
            end
            chk($sformatf("model_oh[%0d]@%0d", n, cyc), d_oh(n), m_oh[n]);
            chk($sformatf("model_fb[%0d]@%0d", n, cyc), 64'(d_fb(n)), 64'(eb));
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
    endtask

    task automatic idle(input int c);
        req_valid = '0;
        fu_stall  = '0;
        flush     = 1'b0;
        repeat (c) step();
    endtask

    initial begin
        logic [2:0] v3;
        bit exp_g, exp_b;

        for (int n = 0; n < 3; n++) begin
            m_gv[n] = '0;
            m_oh[n] = '0;
            for (int f = 0; f < 3; f++) begin
                m_rr[n][f] = 0; m_ready[n][f] = 0; m_gi[n][f] = 0;
            end
        end

        // Reset held with every entry requesting FU0.
        reset_n   = 1'b0;
        flush     = 1'b0;
        fu_stall  = '0;
        req_valid = '1;
        req_fu    = '0;
        step();
        step();
        chk("rst_gv", 64'(d_gv(0)), 64'd0);
        chk("rst_oh", d_oh(0), 64'd0);
        chk("rst_fb", 64'(d_fb(2)), 64'd0);
        reset_n = 1'b1;
        step();
        chk("first_gv", 64'(d_gv(0)), 64'd1);
        chk("first_idx", 64'(d_gidx(0, 0)), 64'd0);
        idle(5);

        // A single request on FU1, held, is not granted again in the next cycle.
        req_fu        = '1;
        req_fu[11:10] = 2'd1;
        req_valid     = '0;
        req_valid[5]  = 1'b1;
        step();
        chk("single_gv", 64'(d_gv(0)), 64'b010);
        chk("single_idx", 64'(d_gidx(0, 1)), 64'd5);
        chk("single_oh", d_oh(0), 64'h20);
        step();
        chk("single_noregrant", 64'(d_gv(0)), 64'd0);
        idle(5);

        // Round robin on FU0; the FU0 pointer is 1 after the first grant.
        req_fu        = '1;
        req_fu[5:4]   = 2'd0;
        req_fu[19:18] = 2'd0;
        req_valid[2]  = 1'b1;
        req_valid[9]  = 1'b1;
        step();
        chk("rr_first", 64'(d_gidx(0, 0)), 64'd2);
        req_valid[2] = 1'b0;
        step();
        chk("rr_second_gv", 64'(d_gv(0)), 64'b001);
        chk("rr_second", 64'(d_gidx(0, 0)), 64'd9);
        req_valid[9]  = 1'b0;
        req_fu[7:6]   = 2'd0;
        req_fu[25:24] = 2'd0;
        req_valid[3]  = 1'b1;
        req_valid[12] = 1'b1;
        step();
        chk("rr_wrap_a", 64'(d_gidx(0, 0)), 64'd12);
        req_valid[12] = 1'b0;
        step();
        chk("rr_wrap_b", 64'(d_gidx(0, 0)), 64'd3);
        idle(6);

        // Busy window with FU_BUSY_CYCLES=3: entries 1, 2 and 3 on FU2.
        req_fu      = '1;
        req_fu[3:2] = 2'd2;
        req_fu[5:4] = 2'd2;
        req_fu[7:6] = 2'd2;
        req_valid   = 64'h0E;
        for (int c = 1; c <= 7; c++) begin
            step();
            exp_g = (c == 1 || c == 4 || c == 7);
            exp_b = (c != 3 && c != 6);
            v3 = d_gv(1);
            chk($sformatf("busy_gv_c%0d", c), 64'(v3[2]), 64'(exp_g));
            v3 = d_fb(1);
            chk($sformatf("busy_fb_c%0d", c), 64'(v3[2]), 64'(exp_b));
            if (exp_g) chk($sformatf("busy_idx_c%0d", c), 64'(d_gidx(1, 2)), 64'((c + 2) / 3));
        end
        idle(6);

        // Parallel grants while FU0 is stalled.
        req_fu      = '1;
        req_fu[1:0] = 2'd0;
        req_fu[3:2] = 2'd1;
        req_fu[5:4] = 2'd2;
        req_valid   = 64'h7;
        fu_stall    = 3'b001;
        step();
        chk("stall_gv", 64'(d_gv(0)), 64'b110);
        req_valid[1] = 1'b0;
        req_valid[2] = 1'b0;
        fu_stall     = '0;
        step();
        chk("unstall_gv", 64'(d_gv(0)), 64'b001);
        chk("unstall_idx", 64'(d_gidx(0, 0)), 64'd0);
        idle(6);

        // Flush inside a FU_BUSY_CYCLES=4 busy window.
        req_fu        = '1;
        req_fu[13:12] = 2'd0;
        req_fu[15:14] = 2'd0;
        req_valid     = 64'hC0;
        step();
        v3 = d_gv(2);
        chk("flush_pre_gv", 64'(v3[0]), 64'd1);
        v3 = d_fb(2);
        chk("flush_pre_fb", 64'(v3[0]), 64'd1);
        flush = 1'b1;
        step();
        chk("flush_gv", 64'(d_gv(2)), 64'd0);
        chk("flush_fb", 64'(d_fb(2)), 64'd0);
        chk("flush_oh", d_oh(2), 64'd0);
        flush = 1'b0;
        step();
        v3 = d_gv(2);
        chk("flush_regrant", 64'(v3[0]), 64'd1);
        idle(5);

        // Random traffic, including occasional reset and flush.
        repeat (400) begin
            reset_n   = ($urandom_range(0, 99) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            fu_stall  = 3'($urandom & $urandom);
            req_valid = {$urandom, $urandom} & {$urandom, $urandom};
            req_fu    = {$urandom, $urandom, $urandom, $urandom};
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
